// File: rtl/router_input_arbiter.sv
// Round-robin arbiter that lets NUM_SRC packet sources share one router input.
// A granted source streams bytes through a one-cycle register stage to the
// router. Every packet is followed by a fixed idle gap and a wait for the
// router to finish with it. Packet outcomes (complete, underrun, oversize)
// are tallied in saturating 16-bit counters.
module router_input_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_PKT    = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_gnt,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           rtr_inp,
  output logic                 rtr_inp_valid,
  input  logic                 rtr_busy,
  output logic [15:0]          pkt_count,
  output logic [15:0]          underrun_count,
  output logic [15:0]          oversize_count
);

  localparam int PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W    = $clog2(MAX_PKT + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_GAP       = 2'd2;
  localparam logic [1:0] S_WAIT_BUSY = 2'd3;
  // With no gap requested a finished packet goes straight to the busy wait.
  localparam logic [1:0] S_AFTER_PKT = (GAP_CYCLES > 0) ? S_GAP : S_WAIT_BUSY;

  logic [1:0]         state_q,     state_d;
  logic [NUM_SRC-1:0] gnt_q,       gnt_d;
  logic [PTR_W-1:0]   gsel_q,      gsel_d;
  logic [PTR_W-1:0]   ptr_q,       ptr_d;
  logic [CNT_W-1:0]   byte_cnt_q,  byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic [7:0]         rtr_inp_q,   rtr_inp_d;
  logic               rtr_valid_q, rtr_valid_d;
  logic [15:0]        pkt_q,       pkt_d;
  logic [15:0]        under_q,     under_d;
  logic [15:0]        over_q,      over_d;
  logic               armed_q;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic [NUM_SRC-1:0] win_onehot;
  logic [PTR_W-1:0]   cand_idx;
  int                 cand;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping to 0.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = 0;
    cand_idx   = '0;
    win_onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_SRC;
      cand_idx = PTR_W'(cand);
      if (!win_found && src_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      win_onehot[i] = (win_idx == PTR_W'(i));
    end
    win_next = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
  end

  // Byte-lane multiplexer for the currently granted source.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gsel_q == PTR_W'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: grant, forward, gap, then wait for the router.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gsel_d      = gsel_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_d       = pkt_q;
    under_d     = under_q;
    over_d      = over_q;
    // The router byte is zero unless a byte is actually forwarded this cycle.
    rtr_valid_d = 1'b0;
    rtr_inp_d   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (armed_q && !rtr_busy && win_found) begin
          gnt_d      = win_onehot;
          gsel_d     = win_idx;
          ptr_d      = win_next;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        gap_cnt_d = '0;
        if (sel_valid) begin
          rtr_valid_d = 1'b1;
          rtr_inp_d   = sel_data;
          byte_cnt_d  = byte_cnt_q + 1'b1;
          if (sel_last) begin
            pkt_d   = sat_inc(pkt_q);
            state_d = S_AFTER_PKT;
          end else if (byte_cnt_q == CNT_W'(MAX_PKT - 1)) begin
            over_d  = sat_inc(over_q);
            state_d = S_AFTER_PKT;
          end
        end else begin
          // Source stalled mid-packet: the router sees a short packet.
          under_d = sat_inc(under_q);
          state_d = S_AFTER_PKT;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = S_WAIT_BUSY;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!rtr_busy) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything, including a packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath register is reset too, because the router byte must
    // read zero whenever it is not valid, including straight out of reset.
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gsel_q      <= '0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rtr_inp_q   <= 8'h00;
      rtr_valid_q <= 1'b0;
      pkt_q       <= '0;
      under_q     <= '0;
      over_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gsel_q      <= gsel_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rtr_inp_q   <= rtr_inp_d;
      rtr_valid_q <= rtr_valid_d;
      pkt_q       <= pkt_d;
      under_q     <= under_d;
      over_q      <= over_d;
      // Blocks granting on the first edge after reset release.
      armed_q     <= 1'b1;
    end
  end

  assign src_gnt        = gnt_q;
  assign src_ready      = gnt_q & {NUM_SRC{state_q == S_SEND}};
  assign rtr_inp        = rtr_inp_q;
  assign rtr_inp_valid  = rtr_valid_q;
  assign pkt_count      = pkt_q;
  assign underrun_count = under_q;
  assign oversize_count = over_q;

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter (4 sources, gap 2, MAX_PKT 16).
module tb_router_input_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  src_req = '0;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  src_gnt;
  logic [3:0]  src_ready;
  logic [7:0]  rtr_inp;
  logic        rtr_inp_valid;
  logic        rtr_busy = 1'b0;
  logic [15:0] pkt_count;
  logic [15:0] underrun_count;
  logic [15:0] oversize_count;

  int n_pass = 0;
  int n_total = 0;

  router_input_arbiter #(.NUM_SRC(4), .GAP_CYCLES(2), .MAX_PKT(16)) dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_gnt(src_gnt), .src_ready(src_ready),
    .rtr_inp(rtr_inp), .rtr_inp_valid(rtr_inp_valid), .rtr_busy(rtr_busy),
    .pkt_count(pkt_count), .underrun_count(underrun_count),
    .oversize_count(oversize_count)
  );

  always #5 clk = ~clk;

  // Source model: packet length, optional stall point, bytes already sent.
  // Byte n (1-based) of source i is i*64+n.
  int len[4]     = '{0, 0, 0, 0};
  int drop_at[4] = '{0, 0, 0, 0};
  int sent[4]    = '{0, 0, 0, 0};
  logic [3:0] gnt_prev = '0;

  always_comb begin
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = (sent[i] < len[i]) && (drop_at[i] == 0 || sent[i] < drop_at[i]);
      src_last[i]  = src_valid[i] && (sent[i] == len[i] - 1);
      src_data[8*i +: 8] = 8'(i * 64 + sent[i] + 1);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || (gnt_prev[i] && !src_gnt[i])) sent[i] <= 0;
      else if (src_ready[i] && src_valid[i])      sent[i] <= sent[i] + 1;
    end
    gnt_prev <= src_gnt;
  end

  // Router-side monitor: byte log, valid run lengths, idle gaps, grant order.
  logic [7:0] byte_log[$];
  int         runs[$];
  int         gaps[$];
  int         gnt_log[$];
  int         high_run = 0;
  int         low_run = 0;
  int         bad_zero = 0;
  logic       prev_valid = 1'b0;
  logic       seen_pkt = 1'b0;
  logic [3:0] gnt_seen = '0;

  always @(negedge clk) begin
    if (rtr_inp_valid) begin
      byte_log.push_back(rtr_inp);
      if (!prev_valid && seen_pkt) gaps.push_back(low_run);
      high_run <= prev_valid ? high_run + 1 : 1;
    end else begin
      if (prev_valid) begin
        runs.push_back(high_run);
        seen_pkt <= 1'b1;
      end
      low_run <= prev_valid ? 1 : low_run + 1;
      if (rtr_inp !== 8'h00) bad_zero <= bad_zero + 1;
    end
    prev_valid <= rtr_inp_valid;
    if (src_gnt !== gnt_seen && src_gnt !== 4'b0000) begin
      for (int i = 0; i < 4; i++) if (src_gnt[i]) gnt_log.push_back(i);
    end
    gnt_seen <= src_gnt;
  end

  task automatic do_reset();
    src_req  = '0;
    rtr_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len[i]     = 0;
      drop_at[i] = 0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (src_gnt === 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pkt_end(input int bound, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rtr_inp_valid === 1'b1) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if ({src_gnt, src_ready} !== 8'h00) $display("FAIL rst_gnt_ready: got %h want 00", {src_gnt, src_ready}); else n_pass++;
    n_total++; if ({rtr_inp_valid, rtr_inp} !== 9'h000) $display("FAIL rst_rtr: got %h want 000", {rtr_inp_valid, rtr_inp}); else n_pass++;
    n_total++; if ({pkt_count, underrun_count, oversize_count} !== 48'h0) $display("FAIL rst_counts: got %h want 0", {pkt_count, underrun_count, oversize_count}); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (src_gnt !== 4'b0000) $display("FAIL rst_idle_no_req: got %b want 0000", src_gnt); else n_pass++;
  endtask

  task automatic test_single();
    int  b0;
    int  nbad;
    bit  ok;
    do_reset();
    b0 = byte_log.size();
    len[0] = 12;
    src_req[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src_ready[0] && src_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++; if (!ok) $display("FAIL single_accept: got timeout want src_ready[0]"); else n_pass++;
    n_total++; if (rtr_inp_valid !== 1'b0) $display("FAIL single_pre_valid: got %b want 0", rtr_inp_valid); else n_pass++;
    @(negedge clk);
    n_total++; if ({rtr_inp_valid, rtr_inp} !== 9'h101) $display("FAIL single_latency: got %h want 101", {rtr_inp_valid, rtr_inp}); else n_pass++;
    wait_gnt_idle(100, ok);
    src_req[0] = 1'b0;
    n_total++; if (!ok) $display("FAIL single_done: got timeout want grant release"); else n_pass++;
    n_total++; if (byte_log.size() - b0 !== 12) $display("FAIL single_nbytes: got %0d want 12", byte_log.size() - b0); else n_pass++;
    nbad = 0;
    for (int k = 0; k < 12; k++) if (byte_log[b0 + k] !== 8'(k + 1)) nbad++;
    n_total++; if (nbad !== 0) $display("FAIL single_bytes: got %0d wrong bytes want 0", nbad); else n_pass++;
    n_total++; if (runs[$] !== 12) $display("FAIL single_run: got %0d want 12", runs[$]); else n_pass++;
    n_total++; if (pkt_count !== 16'd1) $display("FAIL single_pkt_count: got %0d want 1", pkt_count); else n_pass++;
  endtask

  task automatic test_round_robin();
    int g0;
    int p0;
    int nbad;
    bit ok;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    g0 = gnt_log.size();
    p0 = gaps.size();
    for (int i = 0; i < 4; i++) len[i] = 3;
    src_req = 4'b1111;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gnt_log.size() >= g0 + 5) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++; if (!ok) $display("FAIL rr_grants: got %0d grants want 5", gnt_log.size() - g0); else n_pass++;
    wait_gnt_idle(100, ok);
    src_req = 4'b0000;
    n_total++; if (!ok) $display("FAIL rr_done: got timeout want grant release"); else n_pass++;
    nbad = 0;
    for (int k = 0; k < 5; k++) if (gnt_log[g0 + k] !== exp_order[k]) nbad++;
    n_total++; if (nbad !== 0) $display("FAIL rr_order: got %0d %0d %0d %0d %0d want 0 1 2 3 0",
      gnt_log[g0], gnt_log[g0+1], gnt_log[g0+2], gnt_log[g0+3], gnt_log[g0+4]); else n_pass++;
    nbad = 0;
    for (int k = p0 + 1; k < gaps.size(); k++) if (gaps[k] !== 4) nbad++;
    n_total++; if (gaps.size() - p0 !== 5 || nbad !== 0) $display("FAIL rr_gaps: got %0d gaps, %0d not 4 want 5 gaps of 4", gaps.size() - p0, nbad); else n_pass++;
    n_total++; if (pkt_count !== 16'd5) $display("FAIL rr_pkt_count: got %0d want 5", pkt_count); else n_pass++;
  endtask

  task automatic test_busy();
    bit ok;
    int err_g;
    int err_v;
    do_reset();
    len[0] = 4;
    len[1] = 4;
    src_req = 4'b0011;
    wait_pkt_end(50, ok);
    rtr_busy   = 1'b1;
    src_req[0] = 1'b0;
    n_total++; if (!ok) $display("FAIL busy_first_pkt: got timeout want packet end"); else n_pass++;
    err_g = 0;
    err_v = 0;
    repeat (20) begin
      @(negedge clk);
      if (src_gnt !== 4'b0001) err_g++;
      if (rtr_inp_valid !== 1'b0) err_v++;
    end
    n_total++; if (err_g !== 0) $display("FAIL busy_gnt_held: got %0d bad cycles want 0", err_g); else n_pass++;
    n_total++; if (err_v !== 0) $display("FAIL busy_no_valid: got %0d bad cycles want 0", err_v); else n_pass++;
    rtr_busy = 1'b0;
    @(negedge clk);
    n_total++; if (src_gnt !== 4'b0000) $display("FAIL busy_release: got %b want 0000", src_gnt); else n_pass++;
    @(negedge clk);
    n_total++; if (src_gnt !== 4'b0010) $display("FAIL busy_next_grant: got %b want 0010", src_gnt); else n_pass++;
    wait_gnt_idle(100, ok);
    src_req = 4'b0000;
    n_total++; if (!ok || pkt_count !== 16'd2) $display("FAIL busy_pkt_count: got %0d want 2", pkt_count); else n_pass++;
  endtask

  task automatic test_underrun();
    int b0;
    int nbad;
    bit ok;
    do_reset();
    b0 = byte_log.size();
    len[1]     = 10;
    drop_at[1] = 5;
    src_req[1] = 1'b1;
    wait_pkt_end(50, ok);
    n_total++; if (!ok) $display("FAIL under_end: got timeout want packet end"); else n_pass++;
    n_total++; if ({src_gnt, src_ready} !== 8'h20) $display("FAIL under_gap: got gnt/ready %h want 20", {src_gnt, src_ready}); else n_pass++;
    wait_gnt_idle(100, ok);
    src_req[1] = 1'b0;
    n_total++; if (!ok) $display("FAIL under_done: got timeout want grant release"); else n_pass++;
    nbad = 0;
    for (int k = 0; k < 5; k++) if (byte_log[b0 + k] !== 8'(64 + k + 1)) nbad++;
    n_total++; if (byte_log.size() - b0 !== 5 || nbad !== 0) $display("FAIL under_bytes: got %0d bytes %0d wrong want 5 correct", byte_log.size() - b0, nbad); else n_pass++;
    n_total++; if (runs[$] !== 5) $display("FAIL under_run: got %0d want 5", runs[$]); else n_pass++;
    n_total++; if ({underrun_count, pkt_count} !== {16'd1, 16'd0}) $display("FAIL under_counts: got under %0d pkt %0d want 1 0", underrun_count, pkt_count); else n_pass++;
  endtask

  task automatic test_oversize();
    int b0;
    bit ok;
    do_reset();
    b0 = byte_log.size();
    len[2]     = 20;
    src_req[2] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rtr_inp_valid && rtr_inp === 8'h90) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++; if (!ok) $display("FAIL over_byte16: got timeout want byte 90"); else n_pass++;
    n_total++; if (src_ready !== 4'b0000) $display("FAIL over_ready_drop: got %b want 0000", src_ready); else n_pass++;
    wait_gnt_idle(100, ok);
    src_req[2] = 1'b0;
    n_total++; if (!ok) $display("FAIL over_done: got timeout want grant release"); else n_pass++;
    n_total++; if (byte_log.size() - b0 !== 16) $display("FAIL over_nbytes: got %0d want 16", byte_log.size() - b0); else n_pass++;
    n_total++; if (runs[$] !== 16) $display("FAIL over_run: got %0d want 16", runs[$]); else n_pass++;
    n_total++; if ({oversize_count, pkt_count, underrun_count} !== {16'd1, 16'd0, 16'd0}) $display("FAIL over_counts: got over %0d pkt %0d under %0d want 1 0 0", oversize_count, pkt_count, underrun_count); else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    int  nv;
    bit  ok;
    do_reset();
    len[3]     = 10;
    src_req[3] = 1'b1;
    nv = 0;
    for (int i = 0; i < 40 && nv < 3; i++) begin
      @(negedge clk);
      if (rtr_inp_valid) nv++;
    end
    n_total++; if (nv !== 3 || src_gnt !== 4'b1000) $display("FAIL mid_sending: got %0d bytes gnt %b want 3 1000", nv, src_gnt); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if ({src_gnt, src_ready} !== 8'h00) $display("FAIL mid_rst_gnt: got %h want 00", {src_gnt, src_ready}); else n_pass++;
    n_total++; if ({rtr_inp_valid, rtr_inp} !== 9'h000) $display("FAIL mid_rst_rtr: got %h want 000", {rtr_inp_valid, rtr_inp}); else n_pass++;
    for (int i = 0; i < 4; i++) len[i] = 4;
    src_req = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (src_gnt !== 4'b0000) $display("FAIL mid_first_cycle: got %b want 0000", src_gnt); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (src_gnt !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++; if (!ok || src_gnt !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", src_gnt); else n_pass++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_underrun();
    test_oversize();
    test_reset_mid_send();
    n_total++; if (bad_zero !== 0) $display("FAIL idle_zero: got %0d nonzero idle cycles want 0", bad_zero); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/router_input_arbiter.md
ROUTER_INPUT_ARBITER -- requirements
Module: router_input_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of packet sources sharing one router input.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced after every packet.
REQ-003 SHALL have parameter MAX_PKT, default 2000, maximum bytes forwarded per grant.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port src_req  input  NUM_SRC  per-source request, level, held until packet sent.
REQ-007 SHALL have port src_valid  input  NUM_SRC  per-source byte valid.
REQ-008 SHALL have port src_data  input  8*NUM_SRC  per-source byte; source i on bits [8i+7:8i].
REQ-009 SHALL have port src_last  input  NUM_SRC  per-source last-byte marker, qualified by src_valid.
REQ-010 SHALL have port src_gnt  output  NUM_SRC  one-hot grant, registered.
REQ-011 SHALL have port src_ready  output  NUM_SRC  byte accept; src_ready[i] = src_gnt[i] AND state==SEND (combinational).
REQ-012 SHALL have port rtr_inp  output  8  byte to router input.
REQ-013 SHALL have port rtr_inp_valid  output  1  router input valid.
REQ-014 SHALL have port rtr_busy  input  1  router busy (holding/draining a packet).
REQ-015 SHALL have port pkt_count  output  16  packets completed with src_last, saturating.
REQ-016 SHALL have port underrun_count  output  16  packets cut by src_valid drop, saturating.
REQ-017 SHALL have port oversize_count  output  16  packets truncated at MAX_PKT, saturating.

Function
REQ-018 SHALL implement states IDLE, SEND, GAP, WAIT_BUSY.
REQ-019 SHALL in IDLE with rtr_busy==0 and any src_req set, assert src_gnt to the winner next cycle and enter SEND; no grant while rtr_busy==1.
REQ-020 SHALL select winner round-robin: first requester at or after pointer ptr, wrapping NUM_SRC-1 -> 0; ptr <= winner+1 (mod NUM_SRC) on grant; ptr resets to 0.
REQ-021 SHALL, in SEND, on each cycle src_valid[g]==1 register rtr_inp<=src_data[g], rtr_inp_valid<=1, increment byte counter (1-cycle latency source->router).
REQ-022 SHALL on accepted byte with src_last[g]==1 increment pkt_count and enter GAP.
REQ-023 SHALL on SEND cycle with src_valid[g]==0 (byte count >0 or not) drive rtr_inp_valid<=0, increment underrun_count, enter GAP; the router sees a short packet.
REQ-024 SHALL on accepting byte number MAX_PKT without src_last increment oversize_count and enter GAP; src_ready drops the following cycle.
REQ-025 SHALL keep rtr_inp_valid contiguous within a packet: never high in GAP, WAIT_BUSY, IDLE.
REQ-026 SHALL drive rtr_inp to 8'h00 whenever rtr_inp_valid is 0.
REQ-027 SHALL in GAP hold src_gnt, count exactly GAP_CYCLES cycles, then enter WAIT_BUSY.
REQ-028 SHALL in WAIT_BUSY remain while rtr_busy==1; on rtr_busy==0 clear src_gnt and enter IDLE next cycle.
REQ-029 SHALL ignore src_req changes of the granted source once in SEND; deassertion of src_req alone does not end the packet.
REQ-030 SHALL saturate all counters at 16'hFFFF.
REQ-031 SHALL guarantee minimum packet spacing on rtr_inp_valid of GAP_CYCLES+2 low cycles.

Reset
REQ-032 SHALL on reset asynchronously force state IDLE, src_gnt=0, rtr_inp=0, rtr_inp_valid=0, ptr=0, byte counter=0, all counts=0, including mid-packet.
REQ-033 SHALL grant nothing in the first cycle after reset deassertion.

Verification
REQ-034 SHALL verify single source 0, 12-byte packet, last on byte 12 -> rtr_inp_valid high exactly 12 cycles, bytes in order, one cycle after src accept, pkt_count=1.
REQ-035 SHALL verify all 4 sources requesting continuously -> grant order 0,1,2,3,0; each gap >=4 idle cycles.
REQ-036 SHALL verify rtr_busy held high 20 cycles after packet end -> src_gnt held, no new rtr_inp_valid until rtr_busy falls, then next grant.
REQ-037 SHALL verify source 1 drops src_valid after 5 bytes -> rtr_inp_valid falls after 5 bytes, underrun_count=1, arbiter proceeds to GAP.
REQ-038 SHALL verify MAX_PKT=16, 20-byte packet -> exactly 16 bytes forwarded, oversize_count=1.
REQ-039 SHALL verify reset asserted mid-SEND -> all outputs 0 same cycle, first grant after release goes to source 0.
